// File: rtl/dll_trk_pkg.sv
// ---------------------------------------------------------------------------
// dll_trk_pkg
// Shared types and default constants for the FMDLL tracking / lock-detect
// stage (dll_track_lock and its vote filter).
//   trk_state_e : controller states IDLE / LOAD / TRACK
//   trk_dir_e   : direction of the last code step (NONE / UP / DN)
//   DEF_*       : default parameter values for the top level
// ---------------------------------------------------------------------------
package dll_trk_pkg;

  localparam int DEF_CODE_W   = 10;
  localparam int DEF_TH       = 4;
  localparam int DEF_LOCK_REV = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_TRACK = 2'd2
  } trk_state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } trk_dir_e;

endpackage

// File: rtl/trk_vote_filter.sv
// ---------------------------------------------------------------------------
// trk_vote_filter
// Majority-style vote filter for phase-detector decisions. A signed
// accumulator moves +1 for comp=1 and -1 for comp=0 on every comp_valid
// strobe. When the updated value would reach +TH or -TH, a one-cycle step
// pulse is produced (combinationally, in the strobe cycle) and the
// accumulator restarts from zero.
// Ports:
//   clk_ext    in  clock
//   rst_n      in  asynchronous active-low reset
//   comp       in  PD decision (1 = vote up, 0 = vote down)
//   comp_valid in  one-cycle strobe qualifying comp
//   clr        in  synchronous clear of the accumulator, dominates strobes
//   step_up    out pulse: vote reached +TH this cycle
//   step_dn    out pulse: vote reached -TH this cycle
// ---------------------------------------------------------------------------
module trk_vote_filter #(
  parameter int TH = 4
) (
  input  logic clk_ext,
  input  logic rst_n,
  input  logic comp,
  input  logic comp_valid,
  input  logic clr,
  output logic step_up,
  output logic step_dn
);

  // One sign bit plus enough magnitude to hold TH.
  localparam int ACC_W = $clog2(TH + 1) + 1;

  localparam logic signed [ACC_W-1:0] TH_POS = ACC_W'(TH);
  localparam logic signed [ACC_W-1:0] TH_NEG = -TH_POS;
  localparam logic signed [ACC_W-1:0] ONE    = ACC_W'(1);

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_acc_next;

  always_comb begin
    w_acc_next = r_acc;
    if (comp_valid) begin
      w_acc_next = comp ? (r_acc + ONE) : (r_acc - ONE);
    end
  end

  assign step_up = !clr && comp_valid &&  comp && (w_acc_next == TH_POS);
  assign step_dn = !clr && comp_valid && !comp && (w_acc_next == TH_NEG);

  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (clr || step_up || step_dn) begin
      r_acc <= '0;
    end else begin
      r_acc <= w_acc_next;
    end
  end

endmodule

// File: rtl/dll_track_lock.sv
// ---------------------------------------------------------------------------
// dll_track_lock
// Post-acquisition tracking and lock detect for the FMDLL delay line.
// Captures the SAR result, then nudges the delay code by +/-1 LSB on each
// filtered phase-detector vote and flags lock once the code has dithered
// (alternated step direction) LOCK_REV times in a row.
// Ports:
//   clk_ext    in  clock, rising edge
//   rst_n      in  asynchronous active-low reset
//   en         in  tracking enable; low returns to IDLE
//   sar_done   in  SAR search complete (level)
//   sar_code   in  final SAR code
//   comp       in  PD decision, 1 = lags (increase code)
//   comp_valid in  strobe qualifying comp
//   code_out   out delay code, split [9:6]/[5:3]/[2:0] by the decoders
//   tracking   out high in TRACK
//   lock       out lock indicator
//   sat        out code pinned at 0 or all-ones while tracking
//   dbg_state  out current controller state (trk_state_e encoding)
//
// Strobe semantics: comp_valid is a fire-and-forget strobe with no ready;
// comp is consumed on every edge where comp_valid is high, the block is in
// TRACK and en is high. Back-to-back strobes are accepted every cycle.
// ---------------------------------------------------------------------------
module dll_track_lock
  import dll_trk_pkg::*;
#(
  parameter int CODE_W   = DEF_CODE_W,
  parameter int TH       = DEF_TH,
  parameter int LOCK_REV = DEF_LOCK_REV
) (
  input  logic              clk_ext,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sar_done,
  input  logic [CODE_W-1:0] sar_code,
  input  logic              comp,
  input  logic              comp_valid,
  output logic [CODE_W-1:0] code_out,
  output logic              tracking,
  output logic              lock,
  output logic              sat,
  output logic [1:0]        dbg_state
);

  localparam int                 REV_W    = $clog2(LOCK_REV + 1);
  localparam logic [REV_W-1:0]   REV_MAX  = REV_W'(LOCK_REV);
  localparam logic [REV_W-1:0]   REV_ONE  = REV_W'(1);
  localparam logic [CODE_W-1:0]  CODE_MAX = {CODE_W{1'b1}};
  localparam logic [CODE_W-1:0]  CODE_ONE = CODE_W'(1);

  trk_state_e        r_state;
  trk_dir_e          r_dir;
  logic [CODE_W-1:0] r_code;
  logic [REV_W-1:0]  r_rev_cnt;
  logic              r_lock;
  logic              r_tracking;

  logic              w_active;
  logic              w_vote_valid;
  logic              w_filt_clr;
  logic              w_step_up;
  logic              w_step_dn;
  trk_dir_e          w_step_dir;
  logic [REV_W-1:0]  w_rev_next;

  // Votes only count while actively tracking; a strobe arriving with en low
  // is dropped because the exit to IDLE wins on that edge.
  assign w_active     = (r_state == ST_TRACK) && en;
  assign w_vote_valid = comp_valid && w_active;
  assign w_filt_clr   = !w_active;

  trk_vote_filter #(
    .TH (TH)
  ) u_vote (
    .clk_ext    (clk_ext),
    .rst_n      (rst_n),
    .comp       (comp),
    .comp_valid (w_vote_valid),
    .clr        (w_filt_clr),
    .step_up    (w_step_up),
    .step_dn    (w_step_dn)
  );

  assign w_step_dir = w_step_up ? DIR_UP : DIR_DN;
  assign w_rev_next = (r_rev_cnt == REV_MAX) ? r_rev_cnt : (r_rev_cnt + REV_ONE);

  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_dir      <= DIR_NONE;
      r_code     <= '0;
      r_rev_cnt  <= '0;
      r_lock     <= 1'b0;
      r_tracking <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // code is intentionally held so the delay line does not glitch
          r_rev_cnt  <= '0;
          r_lock     <= 1'b0;
          r_tracking <= 1'b0;
          if (en && sar_done) begin
            r_state <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          r_code     <= sar_code;
          r_dir      <= DIR_NONE;
          r_rev_cnt  <= '0;
          r_lock     <= 1'b0;
          r_tracking <= 1'b1;
          r_state    <= ST_TRACK;
        end

        ST_TRACK: begin
          if (!en) begin
            r_state    <= ST_IDLE;
            r_tracking <= 1'b0;
            r_lock     <= 1'b0;
            r_rev_cnt  <= '0;
          end else if (w_step_up || w_step_dn) begin
            // A step into a rail leaves the code alone but is still a step
            // for the reversal bookkeeping below.
            if (w_step_up && (r_code != CODE_MAX)) begin
              r_code <= r_code + CODE_ONE;
            end else if (w_step_dn && (r_code != '0)) begin
              r_code <= r_code - CODE_ONE;
            end

            if (r_dir == DIR_NONE) begin
              r_dir <= w_step_dir;
            end else if (w_step_dir != r_dir) begin
              r_dir     <= w_step_dir;
              r_rev_cnt <= w_rev_next;
              if (w_rev_next == REV_MAX) begin
                r_lock <= 1'b1;
              end
            end else begin
              r_rev_cnt <= '0;
              r_lock    <= 1'b0;
            end
          end
        end

        default: begin
          r_state    <= ST_IDLE;
          r_tracking <= 1'b0;
          r_lock     <= 1'b0;
        end
      endcase
    end
  end

  assign code_out  = r_code;
  assign tracking  = r_tracking;
  assign lock      = r_lock;
  assign sat       = r_tracking && ((r_code == '0) || (r_code == CODE_MAX));
  assign dbg_state = r_state;

endmodule

// File: tb/tb_dll_track_lock.sv
// ---------------------------------------------------------------------------
// tb_dll_track_lock
// Directed self-checking bench for dll_track_lock with hand-computed
// expectations (CODE_W=10, TH=4, LOCK_REV=8).
// ---------------------------------------------------------------------------
module tb_dll_track_lock;

  // ---------------- clock / reset ----------------
  logic       clk_ext = 1'b0;
  logic       rst_n;
  logic       en;
  logic       sar_done;
  logic [9:0] sar_code;
  logic       comp;
  logic       comp_valid;
  logic [9:0] code_out;
  logic       tracking;
  logic       lock;
  logic       sat;
  logic [1:0] dbg_state;

  always #5 clk_ext = ~clk_ext;

  dll_track_lock #(
    .CODE_W   (10),
    .TH       (4),
    .LOCK_REV (8)
  ) dut (
    .clk_ext    (clk_ext),
    .rst_n      (rst_n),
    .en         (en),
    .sar_done   (sar_done),
    .sar_code   (sar_code),
    .comp       (comp),
    .comp_valid (comp_valid),
    .code_out   (code_out),
    .tracking   (tracking),
    .lock       (lock),
    .sat        (sat),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_ext);
    #1;
  endtask

  task automatic strobe(input logic c);
    comp       = c;
    comp_valid = 1'b1;
    @(posedge clk_ext);
    #1;
    comp_valid = 1'b0;
  endtask

  task automatic group4(input logic c);
    for (int k = 0; k < 4; k++) strobe(c);
  endtask

  // Drop en for one edge (back to IDLE), then re-enable with a new SAR code.
  task automatic reload(input logic [9:0] code);
    en = 1'b0;
    tick();
    sar_code = code;
    sar_done = 1'b1;
    en       = 1'b1;
    tick();
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n      = 1'b0;
    en         = 1'b1;
    sar_done   = 1'b1;
    sar_code   = 10'd512;
    comp       = 1'b0;
    comp_valid = 1'b0;

    // Reset values
    #12;
    check_eq("rst_code", 32'(code_out), 32'd0);
    check_eq("rst_tracking", 32'(tracking), 32'd0);
    check_eq("rst_lock", 32'(lock), 32'd0);
    check_eq("rst_sat", 32'(sat), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'd0);

    // Capture: LOAD after one edge, TRACK with code after two
    @(negedge clk_ext);
    rst_n = 1'b1;
    tick();
    check_eq("load_state", 32'(dbg_state), 32'd1);
    check_eq("load_tracking", 32'(tracking), 32'd0);
    tick();
    check_eq("trk_code", 32'(code_out), 32'd512);
    check_eq("trk_tracking", 32'(tracking), 32'd1);
    check_eq("trk_lock", 32'(lock), 32'd0);
    check_eq("trk_state", 32'(dbg_state), 32'd2);

    // Voting: sar_done dropping in TRACK changes nothing
    sar_done = 1'b0;
    for (int k = 0; k < 3; k++) strobe(1'b1);
    check_eq("vote3_code", 32'(code_out), 32'd512);
    strobe(1'b1);
    check_eq("vote4_code", 32'(code_out), 32'd513);
    check_eq("vote4_tracking", 32'(tracking), 32'd1);
    strobe(1'b0); strobe(1'b0); strobe(1'b0); strobe(1'b1);  // acc = -2
    check_eq("mixed_code", 32'(code_out), 32'd513);
    strobe(1'b0);                                            // acc = -3
    check_eq("acc_m3_code", 32'(code_out), 32'd513);
    strobe(1'b0);                                            // reaches -4
    check_eq("acc_m4_code", 32'(code_out), 32'd512);
    check_eq("single_rev_lock", 32'(lock), 32'd0);

    // Lock acquisition: 9 alternating steps = 8 reversals
    reload(10'd512);
    check_eq("reload_code", 32'(code_out), 32'd512);
    for (int g = 0; g < 9; g++) begin
      group4((g % 2) == 0);
      if (g == 7) check_eq("lock_after_7rev", 32'(lock), 32'd0);
    end
    check_eq("lock_after_8rev", 32'(lock), 32'd1);
    check_eq("lock_code", 32'(code_out), 32'd513);
    group4(1'b1);                                            // same direction
    check_eq("same_dir_lock", 32'(lock), 32'd0);
    check_eq("same_dir_code", 32'(code_out), 32'd514);

    // Re-lock, then drop en
    for (int g = 0; g < 8; g++) group4((g % 2) == 1);
    check_eq("relock_lock", 32'(lock), 32'd1);
    check_eq("relock_code", 32'(code_out), 32'd514);
    en = 1'b0;
    tick();
    check_eq("en_drop_tracking", 32'(tracking), 32'd0);
    check_eq("en_drop_lock", 32'(lock), 32'd0);
    check_eq("en_drop_code", 32'(code_out), 32'd514);
    sar_code = 10'd300;
    sar_done = 1'b1;
    en       = 1'b1;
    tick();
    check_eq("recap_hold_code", 32'(code_out), 32'd514);
    tick();
    check_eq("recap_code", 32'(code_out), 32'd300);
    check_eq("recap_tracking", 32'(tracking), 32'd1);

    // Saturation at the top rail
    reload(10'd1023);
    check_eq("top_code", 32'(code_out), 32'd1023);
    check_eq("top_sat", 32'(sat), 32'd1);
    for (int k = 0; k < 8; k++) strobe(1'b1);
    check_eq("top_nowrap_code", 32'(code_out), 32'd1023);
    check_eq("top_nowrap_sat", 32'(sat), 32'd1);

    // Saturation at the bottom rail
    reload(10'd0);
    check_eq("bot_sat", 32'(sat), 32'd1);
    for (int k = 0; k < 8; k++) strobe(1'b0);
    check_eq("bot_nowrap_code", 32'(code_out), 32'd0);
    check_eq("bot_nowrap_sat", 32'(sat), 32'd1);
    group4(1'b1);                        // saturated steps left acc at 0
    check_eq("bot_exit_code", 32'(code_out), 32'd1);
    check_eq("bot_exit_sat", 32'(sat), 32'd0);

    // Strobe coinciding with en low is ignored
    for (int k = 0; k < 3; k++) strobe(1'b1);
    en = 1'b0;
    strobe(1'b1);
    check_eq("en_low_strobe_code", 32'(code_out), 32'd1);
    check_eq("en_low_strobe_tracking", 32'(tracking), 32'd0);

    // Asynchronous reset mid-vote with lock held and acc = 3
    reload(10'd512);
    for (int g = 0; g < 9; g++) group4((g % 2) == 0);
    check_eq("pre_rst_lock", 32'(lock), 32'd1);
    for (int k = 0; k < 3; k++) strobe(1'b1);
    check_eq("pre_rst_code", 32'(code_out), 32'd513);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_code", 32'(code_out), 32'd0);
    check_eq("async_rst_tracking", 32'(tracking), 32'd0);
    check_eq("async_rst_lock", 32'(lock), 32'd0);
    check_eq("async_rst_sat", 32'(sat), 32'd0);
    check_eq("async_rst_state", 32'(dbg_state), 32'd0);

    // After reset the accumulator must start from zero again
    @(negedge clk_ext);
    rst_n = 1'b1;
    tick();
    tick();
    check_eq("post_rst_code", 32'(code_out), 32'd512);
    for (int k = 0; k < 3; k++) strobe(1'b1);
    check_eq("post_rst_acc_clear", 32'(code_out), 32'd512);
    strobe(1'b1);
    check_eq("post_rst_step", 32'(code_out), 32'd513);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got %0d checks expected completion", n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dll_track_lock.md
# dll_track_lock

Post-acquisition tracking and lock-detect stage of the FMDLL delay-line control path. After the 10-bit SAR finishes its binary search, this block captures the SAR code and takes over the delay code. It nudges the code ±1 LSB based on a majority-filtered phase-detector decision, and declares lock once the code dithers steadily. Its code output drives the 4-to-16 coarse decoder and the two 3-to-8 fine decoders, split as [9:6], [5:3] and [2:0].

## Interface
Parameters:
- CODE_W, 10, delay-code width.
- TH, 4, filter vote threshold, ≥2.
- LOCK_REV, 8, consecutive direction reversals required for lock, ≥2.

Ports:
- clk_ext  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  tracking enable; low returns block to IDLE.
- sar_done  in  1  level; SAR search complete, sar_code valid.
- sar_code  in  CODE_W  final SAR code.
- comp  in  1  PD decision: 1 = clock lags (increase delay code), 0 = leads.
- comp_valid  in  1  one-cycle strobe; comp sampled only when high.
- code_out  out  CODE_W  delay code to decoders.
- tracking  out  1  high in TRACK state.
- lock  out  1  lock indicator.
- sat  out  1  code at 0 or max in TRACK.

## Operation
- States: IDLE, LOAD, TRACK.
- IDLE:
  - code_out holds its last value.
  - acc, rev_cnt and lock are cleared.
  - Goes to LOAD when en && sar_done.
- LOAD: code_out <= sar_code; go to TRACK.
- TRACK:
  - Go to IDLE whenever en is low. This takes priority over every TRACK action on that edge.
  - On comp_valid, the signed accumulator acc moves +1 for comp=1 and −1 for comp=0.
  - If the new value would reach +TH: code_out += 1, saturating at 2^CODE_W−1. acc <= 0, dir <= UP.
  - If the new value would reach −TH: code_out −= 1, saturating at 0. acc <= 0, dir <= DN.
  - A saturated step leaves the code unchanged but still clears acc and counts as a step in that direction.
- Lock logic, evaluated on each step:
  - A step opposite to the previous dir increments rev_cnt, saturating at LOCK_REV.
  - A step in the same direction clears rev_cnt and lock.
  - The first step after LOAD has no previous direction. It sets dir and leaves rev_cnt at 0.
  - lock is set when rev_cnt reaches LOCK_REV. It is cleared by a same-direction step, by leaving TRACK, or by reset.
- sat = tracking && (code_out == 0 || code_out == all-ones). It is combinational from registers.
- When sar_done drops while in TRACK, nothing happens. The block re-captures only via IDLE.

## Timing
- Reset values: state = IDLE, code_out = 0, acc = 0, rev_cnt = 0, dir = none, lock = 0, tracking = 0, sat = 0.
- IDLE→LOAD→TRACK: code_out = sar_code on the edge after the first edge that sees en && sar_done. tracking goes high on that same edge.
- Strobe to code: if comp_valid at edge n completes the vote, code_out changes at edge n (registered, visible in cycle n+1). acc is cleared at that same edge n.
- lock rises on the edge whose step makes rev_cnt == LOCK_REV.
- comp_valid with en low in TRACK: the strobe is ignored, and the state goes to IDLE.
- Back-to-back strobes are legal on every cycle.
- Reset asserted mid-operation immediately forces all reset values, including code_out = 0.

## Structure
- Shared package dll_trk_pkg holds:
  - the state enum (IDLE, LOAD, TRACK);
  - the dir encoding (NONE, UP, DN);
  - the default CODE_W, TH and LOCK_REV constants.
- Sub-module trk_vote_filter holds the accumulator and threshold compare.
  - Inputs: comp, comp_valid, clr.
  - Outputs: step_up and step_dn pulses.
- Top level holds the FSM, the code register, and the reversal/lock logic.

## Test plan
- Reset, then en = 1, sar_done = 1, sar_code = 10'd512: code_out = 512 and tracking = 1 two edges after release. lock = 0.
- From 512, 4 strobes with comp = 1: code_out = 513 on the 4th strobe edge. Then 3 strobes with comp = 0 and 1 with comp = 1: code unchanged, acc = −2.
- From 512, alternate groups of 4 up / 4 down strobes: lock rises on the 8th reversal, i.e. the 9th step. A following same-direction step drops lock.
- sar_code = 1023, then 8 strobes with comp = 1: code stays 1023, sat = 1, no wrap to 0. Mirror case: sar_code = 0 with comp = 0 stays at 0.
- While locked, drop en: next edge gives tracking = 0, lock = 0, code_out held. Re-assert en with sar_code = 300: code_out = 300 after 2 edges.
- Assert rst_n low mid-vote with acc = 3 and lock = 1: all outputs go to reset values immediately, without waiting for a clock edge.
